// File: rtl/reverb_param_pio_bank_if.sv
// rtl/reverb_param_pio_bank_if.sv - Avalon-MM slave bus bundle for the reverb parameter bank
//
// Signals:
//   address    word address (ADDR_W bits)
//   chipselect slave select
//   write_n    write strobe, active-low
//   writedata  32-bit write data
//   readdata   32-bit read data, zero wait states
// Modports: master drives the request side, slave returns readdata.
interface reverb_param_pio_bank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/reverb_param_pio_bank.sv
// rtl/reverb_param_pio_bank.sv - shadowed, atomically committed, slew-limited reverb parameter bank
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   bus          Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   sample_tick  one-clk pulse per audio sample; paces the output ramp
//   out_port     current values, channel i at [i*W +: W]
//   busy         high while any current value differs from its target
//
// Address map: 0..NUM_CH-1 shadows (rw), NUM_CH..2*NUM_CH-1 currents (ro),
// 2*NUM_CH CTRL {bypass, commit}, 2*NUM_CH+1 STATUS {W, NUM_CH, busy}.
module reverb_param_pio_bank #(
  parameter int             NUM_CH    = 4,
  parameter int             W         = 24,
  parameter logic [W-1:0]   STEP      = 24'h000100,
  parameter logic [W-1:0]   RESET_VAL = '0,
  parameter int             ADDR_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  reverb_param_pio_bank_if.slave    bus,
  input  logic                      sample_tick,
  output logic [NUM_CH*W-1:0]       out_port,
  output logic                      busy
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2 * NUM_CH);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(2 * NUM_CH + 1);
  localparam logic [W:0]        STEP_X    = {1'b0, STEP};

  logic [W-1:0] shadow   [NUM_CH];
  logic [W-1:0] target   [NUM_CH];
  logic [W-1:0] current  [NUM_CH];
  logic [W-1:0] cur_next [NUM_CH];
  logic [W:0]   up_gap   [NUM_CH];
  logic [W:0]   dn_gap   [NUM_CH];
  logic         bypass;
  logic         wr;
  logic         commit;
  logic         unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign commit       = wr && (bus.address == CTRL_ADDR) && bus.writedata[0];
  // writedata bits above W and above CTRL bit1 carry no meaning here.
  assign unused_wdata = ^bus.writedata;

  // Per-channel slew limiter. Gaps are taken in W+1 bits so the comparison
  // against STEP never wraps; a step is only taken when it cannot overshoot,
  // otherwise the output lands exactly on target.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      up_gap[i]   = {1'b0, target[i]} - {1'b0, current[i]};
      dn_gap[i]   = {1'b0, current[i]} - {1'b0, target[i]};
      cur_next[i] = current[i];
      if (bypass) begin
        cur_next[i] = target[i];
      end else if (sample_tick) begin
        if (current[i] < target[i]) begin
          cur_next[i] = (up_gap[i] > STEP_X) ? current[i] + STEP : target[i];
        end else if (current[i] > target[i]) begin
          cur_next[i] = (dn_gap[i] > STEP_X) ? current[i] - STEP : target[i];
        end
      end
    end
  end

  // target is read before it is updated, so a commit coinciding with a tick
  // steps toward the old target, and bypass shows the new target one clk late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i]  <= RESET_VAL;
        target[i]  <= RESET_VAL;
        current[i] <= RESET_VAL;
      end
      bypass <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && (bus.address == ADDR_W'(i))) begin
          shadow[i] <= bus.writedata[W-1:0];
        end
        if (commit) begin
          target[i] <= shadow[i];
        end
        current[i] <= cur_next[i];
      end
      if (wr && (bus.address == CTRL_ADDR)) begin
        bypass <= bus.writedata[1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy = busy | (current[i] != target[i]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_out
      assign out_port[g*W +: W] = current[g];
    end
  endgenerate

  always_comb begin
    bus.readdata = 32'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.address == ADDR_W'(i)) begin
        bus.readdata = 32'(shadow[i]);
      end
      if (bus.address == ADDR_W'(NUM_CH + i)) begin
        bus.readdata = 32'(current[i]);
      end
    end
    if (bus.address == CTRL_ADDR) begin
      bus.readdata = {30'h0, bypass, 1'b0};
    end
    if (bus.address == STAT_ADDR) begin
      bus.readdata = {8'h0, 8'(W), 8'(NUM_CH), 7'h0, busy};
    end
  end

endmodule

// File: tb/tb_reverb_param_pio_bank.sv
// tb/tb_reverb_param_pio_bank.sv - directed scoreboard bench for reverb_param_pio_bank
module tb_reverb_param_pio_bank;

  localparam int NUM_CH = 4;
  localparam int W      = 24;
  localparam int ADDR_W = 4;

  logic                  clk;
  logic                  reset_n;
  logic                  sample_tick;
  logic [NUM_CH*W-1:0]   out_port;
  logic                  busy;

  reverb_param_pio_bank_if #(.ADDR_W(ADDR_W)) bus ();

  reverb_param_pio_bank #(
    .NUM_CH(NUM_CH), .W(W), .STEP(24'h000100), .RESET_VAL(24'h0), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .sample_tick(sample_tick),
    .out_port(out_port),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] ch(input int i);
    return 32'(out_port[i*W +: W]);
  endfunction

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check channel value and busy right now.
  task automatic chk_ch(input string tag, input int i, input logic [31:0] v);
    push(tag, v);
    pop_check(ch(i));
  endtask

  task automatic chk_busy(input string tag, input logic b);
    push(tag, 32'(b));
    pop_check(32'(busy));
  endtask

  task automatic chk_rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] v);
    logic [31:0] d;
    push(tag, v);
    bus_rd(a, d);
    pop_check(d);
  endtask

  initial begin
    reset_n        = 1'b0;
    sample_tick    = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    idle(3);
    reset_n = 1'b1;

    // Reset state and full address sweep.
    for (int a = 0; a < 16; a++) begin
      chk_rd($sformatf("rst_rd_addr%0d", a), ADDR_W'(a), (a == 9) ? 32'h0018_0400 : 32'h0);
    end
    push("rst_out_zero", 32'h1);
    pop_check(32'(out_port == '0));
    chk_busy("rst_busy", 1'b0);

    // Shadow write without commit never reaches the output.
    bus_wr(4'd0, 32'h0000_0400);
    repeat (10) tick();
    chk_ch("nocommit_ch0", 0, 32'h0);
    chk_busy("nocommit_busy", 1'b0);
    chk_rd("nocommit_shadow0", 4'd0, 32'h0000_0400);
    chk_rd("nocommit_cur0", 4'd4, 32'h0);

    // Commit and ramp up by STEP per tick.
    bus_wr(4'd8, 32'h1);
    chk_ch("commit_no_tick_ch0", 0, 32'h0);
    chk_busy("commit_busy", 1'b1);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) chk_busy("busy_before_t4", 1'b1);
      tick();
      chk_ch($sformatf("up_t%0d", k), 0, 32'h100 * k);
      idle(2);
      chk_ch($sformatf("up_hold_t%0d", k), 0, 32'h100 * k);
    end
    chk_busy("busy_after_t4", 1'b0);

    // Ramp down with clamp.
    bus_wr(4'd0, 32'h0000_0250);
    bus_wr(4'd8, 32'h1);
    tick(); chk_ch("dn_t1", 0, 32'h300);
    tick(); chk_ch("dn_t2_clamp", 0, 32'h250);
    tick(); chk_ch("dn_t3_hold", 0, 32'h250);
    chk_rd("cur0_readback", 4'd4, 32'h250);

    // Extremes: no wrap at the top or bottom of the W range.
    bus_wr(4'd8, 32'h2);
    chk_rd("ctrl_bypass_rd", 4'd8, 32'h2);
    bus_wr(4'd3, 32'h00FF_FF80);
    bus_wr(4'd8, 32'h3);
    idle(1);
    chk_ch("byp_ch3_ffff80", 3, 32'h00FF_FF80);
    bus_wr(4'd8, 32'h0);
    bus_wr(4'd3, 32'h00FF_FFFF);
    bus_wr(4'd8, 32'h1);
    tick(); chk_ch("top_clamp", 3, 32'h00FF_FFFF);
    bus_wr(4'd8, 32'h2);
    bus_wr(4'd3, 32'h0000_0080);
    bus_wr(4'd8, 32'h3);
    idle(1);
    bus_wr(4'd8, 32'h0);
    bus_wr(4'd3, 32'h0);
    bus_wr(4'd8, 32'h1);
    tick(); chk_ch("bottom_clamp", 3, 32'h0);
    bus_wr(4'd8, 32'h2);
    bus_wr(4'd3, 32'h00FF_FFFF);
    bus_wr(4'd8, 32'h3);
    idle(1);
    bus_wr(4'd8, 32'h0);
    bus_wr(4'd3, 32'h0);
    bus_wr(4'd8, 32'h1);
    tick(); chk_ch("ffffff_to_0_t1", 3, 32'h00FF_FEFF);
    chk_busy("ffffff_busy", 1'b1);
    bus_wr(4'd8, 32'h3);
    idle(1);
    chk_ch("ch3_bypass_zero", 3, 32'h0);

    // Bypass: new target on current one clk after the commit edge.
    bus_wr(4'd2, 32'h00AB_CDEF);
    bus_wr(4'd8, 32'h3);
    chk_ch("byp_same_edge_ch2", 2, 32'h0);
    idle(1);
    chk_ch("byp_next_clk_ch2", 2, 32'h00AB_CDEF);
    bus_wr(4'd8, 32'h0);

    // Commit coincident with a tick steps toward the old target.
    bus_wr(4'd2, 32'h0);
    @(negedge clk);
    bus.address    = 4'd8;
    bus.writedata  = 32'h1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    sample_tick    = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    sample_tick    = 1'b0;
    chk_ch("coinc_old_target", 2, 32'h00AB_CDEF);
    chk_busy("coinc_busy", 1'b1);
    tick(); chk_ch("coinc_next_tick", 2, 32'h00AB_CCEF);

    // Reset mid-ramp aborts asynchronously and nothing resumes.
    bus_wr(4'd1, 32'h0000_0800);
    bus_wr(4'd8, 32'h1);
    tick();
    tick();
    chk_ch("midramp_ch1", 1, 32'h200);
    #2 reset_n = 1'b0;
    #1;
    push("async_rst_out", 32'h1);
    pop_check(32'(out_port == '0));
    chk_busy("async_rst_busy", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    push("post_rst_out", 32'h1);
    pop_check(32'(out_port == '0));
    chk_busy("post_rst_busy", 1'b0);
    chk_rd("post_rst_shadow1", 4'd1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
